// File: rtl/sprite_pixel_reader.sv
// Sprite pixel read pipeline: picks the winning sprite, reads the sprite ROM,
// maps the palette index through a writable palette and emits the final RGB.
module sprite_pixel_reader #(
  parameter int unsigned ROM_LATENCY = 2,
  parameter int unsigned ROM_DEPTH   = 40000,
  parameter logic [3:0]  TRANSP_IDX  = 4'd0,
  parameter logic [23:0] ERR_RGB     = 24'hFF00FF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_ce,
  input  logic        is_char,
  input  logic [15:0] char_addr,
  input  logic        is_rz,
  input  logic [15:0] rz_addr,
  input  logic [23:0] bg_rgb,
  output logic [15:0] rom_addr,
  output logic        rom_rd,
  input  logic [3:0]  rom_q,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [23:0] pal_data,
  output logic [23:0] rgb_out,
  output logic        rgb_valid,
  output logic        addr_err,
  input  logic        err_clr
);

  // Handshake: pix_ce is a one-cycle strobe accepted every cycle (no ready);
  // rgb_valid is a one-cycle pulse per accepted strobe, in strobe order.

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CHAR = 2'd1,
    SRC_RZ   = 2'd2,
    SRC_ERR  = 2'd3
  } src_t;

  src_t        w_sel_src;
  logic [15:0] w_sel_addr;
  logic        w_out_of_range;
  logic        w_err_set;
  logic [23:0] w_pix;

  logic        r_cap_v;
  src_t        r_cap_src;
  logic [15:0] r_cap_addr;
  logic [23:0] r_cap_bg;

  logic [15:0] r_rom_addr;
  logic        r_rom_rd;

  logic        r_d_v   [0:ROM_LATENCY];
  src_t        r_d_src [0:ROM_LATENCY];
  logic [23:0] r_d_bg  [0:ROM_LATENCY];

  logic [23:0] r_pal [0:15];
  logic [23:0] r_rgb;
  logic        r_rgb_valid;
  logic        r_addr_err;

  assign rom_addr  = r_rom_addr;
  assign rom_rd    = r_rom_rd;
  assign rgb_out   = r_rgb;
  assign rgb_valid = r_rgb_valid;
  assign addr_err  = r_addr_err;

  // Source selection and range check on the live request inputs.
  always_comb begin
    w_sel_src  = SRC_NONE;
    w_sel_addr = 16'd0;
    if (is_char) begin
      w_sel_src  = SRC_CHAR;
      w_sel_addr = char_addr;
    end else if (is_rz) begin
      w_sel_src  = SRC_RZ;
      w_sel_addr = rz_addr;
    end
    w_out_of_range = (w_sel_src != SRC_NONE) && ({16'd0, w_sel_addr} >= ROM_DEPTH);
    if (w_out_of_range) w_sel_src = SRC_ERR;
    w_err_set = pix_ce && w_out_of_range;
  end

  always_comb begin
    w_pix = r_d_bg[ROM_LATENCY];
    case (r_d_src[ROM_LATENCY])
      SRC_NONE: w_pix = r_d_bg[ROM_LATENCY];
      SRC_ERR:  w_pix = ERR_RGB;
      default:  w_pix = (rom_q == TRANSP_IDX) ? r_d_bg[ROM_LATENCY] : r_pal[rom_q];
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cap_v     <= 1'b0;
      r_cap_src   <= SRC_NONE;
      r_cap_addr  <= 16'd0;
      r_cap_bg    <= 24'd0;
      r_rom_addr  <= 16'd0;
      r_rom_rd    <= 1'b0;
      r_rgb       <= 24'd0;
      r_rgb_valid <= 1'b0;
      r_addr_err  <= 1'b0;
      for (int unsigned i = 0; i <= ROM_LATENCY; i++) begin
        r_d_v[i]   <= 1'b0;
        r_d_src[i] <= SRC_NONE;
        r_d_bg[i]  <= 24'd0;
      end
      for (int i = 0; i < 16; i++) r_pal[i] <= 24'd0;
    end else begin
      r_cap_v    <= pix_ce;
      r_cap_src  <= w_sel_src;
      r_cap_addr <= w_sel_addr;
      r_cap_bg   <= bg_rgb;

      // Only real sprite hits touch the ROM; the address bus idles at 0.
      if (r_cap_v && (r_cap_src == SRC_CHAR || r_cap_src == SRC_RZ)) begin
        r_rom_rd   <= 1'b1;
        r_rom_addr <= r_cap_addr;
      end else begin
        r_rom_rd   <= 1'b0;
        r_rom_addr <= 16'd0;
      end

      r_d_v[0]   <= r_cap_v;
      r_d_src[0] <= r_cap_src;
      r_d_bg[0]  <= r_cap_bg;
      for (int unsigned i = 1; i <= ROM_LATENCY; i++) begin
        r_d_v[i]   <= r_d_v[i-1];
        r_d_src[i] <= r_d_src[i-1];
        r_d_bg[i]  <= r_d_bg[i-1];
      end

      r_rgb_valid <= r_d_v[ROM_LATENCY];
      if (r_d_v[ROM_LATENCY]) r_rgb <= w_pix;

      // A same-cycle lookup of pal_idx sees the old entry.
      if (pal_we) r_pal[pal_idx] <= pal_data;

      if (w_err_set)    r_addr_err <= 1'b1;
      else if (err_clr) r_addr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Directed bench for sprite_pixel_reader with a behavioural pixel model,
// a latency-tagged scoreboard and a per-cycle compare process.
module tb_sprite_pixel_reader;

  localparam int L = 2;

  logic        Clk, Reset, pix_ce, is_char, is_rz, pal_we, err_clr;
  logic [15:0] char_addr, rz_addr, rom_addr;
  logic [23:0] bg_rgb, pal_data, rgb_out;
  logic [3:0]  rom_q, pal_idx;
  logic        rom_rd, rgb_valid, addr_err;

  sprite_pixel_reader #(.ROM_LATENCY(L)) dut (
    .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce),
    .is_char(is_char), .char_addr(char_addr),
    .is_rz(is_rz), .rz_addr(rz_addr), .bg_rgb(bg_rgb),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_q(rom_q),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .rgb_out(rgb_out), .rgb_valid(rgb_valid),
    .addr_err(addr_err), .err_clr(err_clr)
  );

  // ---------------- clock / cycle count ----------------
  int cyc = 0;
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- ROM model: L-cycle synchronous read ----------------
  logic [3:0] mem [0:65535];
  logic [3:0] q_chain [0:L-1];
  always @(posedge Clk) begin
    q_chain[0] <= mem[rom_addr];
    for (int i = 1; i < L; i++) q_chain[i] <= q_chain[i-1];
  end
  assign rom_q = q_chain[L-1];

  // ---------------- behavioural model ----------------
  logic [23:0] pal_m [0:15];

  function automatic logic [23:0] model(input logic ic, input logic [15:0] ca,
                                        input logic ir, input logic [15:0] ra,
                                        input logic [23:0] bg,
                                        output logic rd, output logic [15:0] a_o);
    logic [15:0] a;
    rd  = 1'b0;
    a_o = 16'd0;
    if (!ic && !ir) return bg;
    a = ic ? ca : ra;
    if (int'(a) >= 40000) return 24'hFF00FF;
    rd  = 1'b1;
    a_o = a;
    if (mem[a] == 4'd0) return bg;
    return pal_m[mem[a]];
  endfunction

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int          exp_t_q[$];
  logic [15:0] rom_exp_q[$];
  int          rom_t_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  // Every cycle: ROM port and output pulse must match the scheduled expectations.
  always @(negedge Clk) begin
    if (rom_t_q.size() > 0 && rom_t_q[0] == cyc) begin
      chk("rom_rd", {31'd0, rom_rd}, 32'd1);
      chk("rom_addr", {16'd0, rom_addr}, {16'd0, rom_exp_q[0]});
      void'(rom_t_q.pop_front());
      void'(rom_exp_q.pop_front());
    end else begin
      chk("rom_idle", {15'd0, rom_rd, rom_addr}, 32'd0);
    end
    if (exp_t_q.size() > 0 && exp_t_q[0] == cyc) begin
      chk("rgb_valid", {31'd0, rgb_valid}, 32'd1);
      chk("rgb_out", {8'd0, rgb_out}, {8'd0, exp_q[0]});
      void'(exp_t_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      chk("no_pulse", {31'd0, rgb_valid}, 32'd0);
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic set_idle();
    pix_ce = 0; is_char = 0; char_addr = 0; is_rz = 0; rz_addr = 0; bg_rgb = 0;
    pal_we = 0; pal_idx = 0; pal_data = 0; err_clr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      @(negedge Clk);
    end
  endtask

  task automatic pal_write(input logic [3:0] idx, input logic [23:0] d);
    set_idle();
    pal_we = 1; pal_idx = idx; pal_data = d;
    pal_m[idx] = d;
    @(negedge Clk);
  endtask

  task automatic clr_err();
    set_idle();
    err_clr = 1;
    @(negedge Clk);
  endtask

  task automatic pix(input logic ic, input logic [15:0] ca, input logic ir,
                     input logic [15:0] ra, input logic [23:0] bg, input logic clr);
    logic        rd;
    logic [15:0] a;
    logic [23:0] c;
    set_idle();
    pix_ce = 1; is_char = ic; char_addr = ca; is_rz = ir; rz_addr = ra;
    bg_rgb = bg; err_clr = clr;
    c = model(ic, ca, ir, ra, bg, rd, a);
    if (rd) begin
      rom_exp_q.push_back(a);
      rom_t_q.push_back(cyc + 2);
    end
    exp_q.push_back(c);
    exp_t_q.push_back(cyc + 3 + L);
    @(negedge Clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rom_addr"}, {16'd0, rom_addr}, 32'd0);
    chk({tag, "_rom_rd"}, {31'd0, rom_rd}, 32'd0);
    chk({tag, "_rgb_out"}, {8'd0, rgb_out}, 32'd0);
    chk({tag, "_rgb_valid"}, {31'd0, rgb_valid}, 32'd0);
    chk({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        rd_t;
    logic [15:0] a_t;
    logic [23:0] c_t;
    int          guard;
    for (int i = 0; i < 65536; i++) mem[i] = 4'(i);
    mem[25104] = 4'd3; mem[100] = 4'd5; mem[200] = 4'd0;
    mem[39999] = 4'd7; mem[300] = 4'd9;
    for (int i = 0; i < 8; i++) mem[1000 + i] = 4'(i + 1);
    for (int i = 0; i < 16; i++) pal_m[i] = 24'd0;
    for (int i = 0; i < L; i++) q_chain[i] = 4'd0;

    Reset = 1;
    set_idle();
    repeat (2) @(negedge Clk);
    #2 Reset = 0;
    check_reset_outputs("reset");
    @(negedge Clk);

    // RZ hit through palette entry 3
    pal_write(4'd3, 24'h00FF00);
    c_t = model(1'b0, 16'd0, 1'b1, 16'd25104, 24'hAAAAAA, rd_t, a_t);
    chk("model_rz", {8'd0, c_t}, 32'h0000FF00);
    pix(0, 0, 1, 16'd25104, 24'hAAAAAA, 0);
    idle(6);
    chk("rz_lit", {8'd0, rgb_out}, 32'h0000FF00);

    // CHAR beats RZ
    pal_write(4'd5, 24'h0000FF);
    pix(1, 16'd100, 1, 16'd25104, 24'hAAAAAA, 0);
    idle(6);
    chk("char_prio_lit", {8'd0, rgb_out}, 32'h000000FF);

    // transparency and no-hit background
    pix(0, 0, 1, 16'd200, 24'h123456, 0);
    pix(0, 0, 0, 16'd0, 24'h654321, 0);
    idle(6);
    chk("bg_lit", {8'd0, rgb_out}, 32'h00654321);

    // out-of-range, sticky flag, clear, legal boundary
    pix(0, 0, 1, 16'd40000, 24'h111111, 0);
    chk("err_rise", {31'd0, addr_err}, 32'd1);
    idle(6);
    chk("err_rgb_lit", {8'd0, rgb_out}, 32'h00FF00FF);
    chk("err_sticky", {31'd0, addr_err}, 32'd1);
    clr_err();
    chk("err_clr", {31'd0, addr_err}, 32'd0);
    pal_write(4'd7, 24'hABCDEF);
    pix(0, 0, 1, 16'd39999, 24'h111111, 0);
    chk("no_err_39999", {31'd0, addr_err}, 32'd0);
    idle(6);
    chk("edge_lit", {8'd0, rgb_out}, 32'h00ABCDEF);
    // char out of range wins over a legal RZ; set beats same-cycle clear
    pix(1, 16'd50000, 1, 16'd25104, 24'h222222, 1);
    chk("err_set_wins", {31'd0, addr_err}, 32'd1);
    clr_err();
    chk("err_clr2", {31'd0, addr_err}, 32'd0);
    idle(5);

    // 8 back-to-back pixels
    for (int i = 1; i <= 8; i++) pal_write(4'(i), 24'h010203 * i);
    for (int i = 0; i < 8; i++) pix(0, 0, 1, 16'(1000 + i), 24'h0, 0);
    idle(6);
    chk("burst_last_lit", {8'd0, rgb_out}, 32'h00081018);

    // palette write on the resolve edge: lookup sees old entry
    pal_write(4'd9, 24'h111111);
    pix(0, 0, 1, 16'd300, 24'h0, 0);
    idle(3);
    pal_write(4'd9, 24'h222222);
    idle(3);
    chk("pal_old_lit", {8'd0, rgb_out}, 32'h00111111);
    pix(0, 0, 1, 16'd300, 24'h0, 0);
    idle(6);
    chk("pal_new_lit", {8'd0, rgb_out}, 32'h00222222);

    // reset two cycles after a strobe discards it and clears the palette
    pix(0, 0, 1, 16'd40000, 24'h0, 0);
    idle(6);
    pix(0, 0, 1, 16'd25104, 24'h0, 0);
    idle(1);
    #2 Reset = 1;
    exp_q.delete(); exp_t_q.delete(); rom_exp_q.delete(); rom_t_q.delete();
    for (int i = 0; i < 16; i++) pal_m[i] = 24'd0;
    set_idle();
    repeat (2) @(negedge Clk);
    #2 Reset = 0;
    check_reset_outputs("midreset");
    @(negedge Clk);
    idle(6);
    pix(0, 0, 1, 16'd25104, 24'h333333, 0);
    idle(6);

    guard = 0;
    while ((exp_q.size() > 0 || rom_t_q.size() > 0) && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    chk("drain", exp_q.size() + rom_t_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
